// File: rtl/tlb.sv
// Fully associative TLB: two lookup ports, probe, indexed read and indexed write.
// Define TLB_RESET_CLEAR_EN to have rst zero the whole entry array and drop a simultaneous write.
module tlb #(
  parameter int TLBNUM = 16,
  localparam int IW = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s0_req,
  input  logic [31:0]   s0_vaddr,
  input  logic          s1_req,
  input  logic [31:0]   s1_vaddr,
  input  logic [7:0]    cur_asid,
  output logic          s0_rsp_valid,
  output logic          s0_found,
  output logic [31:0]   s0_paddr,
  output logic [2:0]    s0_c,
  output logic          s0_d,
  output logic          s0_v,
  output logic          s1_rsp_valid,
  output logic          s1_found,
  output logic [31:0]   s1_paddr,
  output logic [2:0]    s1_c,
  output logic          s1_d,
  output logic          s1_v,
  input  logic          tlbp_req,
  input  logic [31:0]   tlbp_entryhi,
  output logic          tlbp_wen,
  output logic [31:0]   tlbp_index,
  input  logic          tlbr_req,
  input  logic [IW-1:0] tlb_index,
  output logic          tlbr_wen,
  output logic [77:0]   tlbr_entry,
  input  logic          tlbwi_wen,
  input  logic [77:0]   tlbwi_entry
);

  logic [77:0] r_entry [TLBNUM];

  logic [TLBNUM-1:0] w_s0_hit, w_s1_hit, w_p_hit;
  logic              w_s0_found, w_s1_found, w_p_found;
  logic [IW-1:0]     w_s0_idx, w_s1_idx, w_p_idx;
  logic [77:0]       w_s0_ent, w_s1_ent;
  logic [24:0]       w_s0_page, w_s1_page;
  logic              w_unused;

  assign w_unused = ^tlbp_entryhi[12:8];

  for (genvar i = 0; i < TLBNUM; i++) begin : g_match
    assign w_s0_hit[i] = (r_entry[i][77:59] == s0_vaddr[31:13]) &&
                         (r_entry[i][50] || (r_entry[i][58:51] == cur_asid));
    assign w_s1_hit[i] = (r_entry[i][77:59] == s1_vaddr[31:13]) &&
                         (r_entry[i][50] || (r_entry[i][58:51] == cur_asid));
    assign w_p_hit[i]  = (r_entry[i][77:59] == tlbp_entryhi[31:13]) &&
                         (r_entry[i][50] || (r_entry[i][58:51] == tlbp_entryhi[7:0]));
  end

  // Scanning downward leaves the lowest matching index as the winner.
  always_comb begin
    w_s0_found = 1'b0;
    w_s1_found = 1'b0;
    w_p_found  = 1'b0;
    w_s0_idx   = '0;
    w_s1_idx   = '0;
    w_p_idx    = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (w_s0_hit[i]) begin
        w_s0_found = 1'b1;
        w_s0_idx   = IW'(i);
      end
      if (w_s1_hit[i]) begin
        w_s1_found = 1'b1;
        w_s1_idx   = IW'(i);
      end
      if (w_p_hit[i]) begin
        w_p_found = 1'b1;
        w_p_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    w_s0_ent  = r_entry[w_s0_idx];
    w_s1_ent  = r_entry[w_s1_idx];
    w_s0_page = s0_vaddr[12] ? w_s0_ent[24:0] : w_s0_ent[49:25];
    w_s1_page = s1_vaddr[12] ? w_s1_ent[24:0] : w_s1_ent[49:25];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_rsp_valid <= 1'b0;
      s0_found     <= 1'b0;
      s0_paddr     <= '0;
      s0_c         <= '0;
      s0_d         <= 1'b0;
      s0_v         <= 1'b0;
      s1_rsp_valid <= 1'b0;
      s1_found     <= 1'b0;
      s1_paddr     <= '0;
      s1_c         <= '0;
      s1_d         <= 1'b0;
      s1_v         <= 1'b0;
      tlbp_wen     <= 1'b0;
      tlbp_index   <= '0;
      tlbr_wen     <= 1'b0;
      tlbr_entry   <= '0;
    end else begin
      s0_rsp_valid <= s0_req;
      s1_rsp_valid <= s1_req;
      tlbp_wen     <= tlbp_req;
      tlbr_wen     <= tlbr_req;
      // Data outputs hold their last response when no request is sampled.
      if (s0_req) begin
        s0_found <= w_s0_found;
        s0_paddr <= w_s0_found ? {w_s0_page[24:5], s0_vaddr[11:0]} : 32'h0;
        s0_c     <= w_s0_found ? w_s0_page[4:2] : 3'h0;
        s0_d     <= w_s0_found & w_s0_page[1];
        s0_v     <= w_s0_found & w_s0_page[0];
      end
      if (s1_req) begin
        s1_found <= w_s1_found;
        s1_paddr <= w_s1_found ? {w_s1_page[24:5], s1_vaddr[11:0]} : 32'h0;
        s1_c     <= w_s1_found ? w_s1_page[4:2] : 3'h0;
        s1_d     <= w_s1_found & w_s1_page[1];
        s1_v     <= w_s1_found & w_s1_page[0];
      end
      if (tlbp_req)
        tlbp_index <= w_p_found ? {{(32-IW){1'b0}}, w_p_idx} : 32'h8000_0000;
      if (tlbr_req)
        tlbr_entry <= r_entry[tlb_index];
    end
  end

  // Lookups above read r_entry before this edge's write lands (read-before-write).
  always_ff @(posedge clk) begin
`ifdef TLB_RESET_CLEAR_EN
    if (rst) begin
      for (int i = 0; i < TLBNUM; i++) r_entry[i] <= '0;
    end else if (tlbwi_wen) begin
      r_entry[tlb_index] <= tlbwi_entry;
    end
`else
    if (tlbwi_wen) r_entry[tlb_index] <= tlbwi_entry;
`endif
  end

endmodule

// File: tb/tb_tlb.sv
// Self-checking bench for tlb: reference lookup model plus directed vectors.
module tb_tlb;
  localparam int TLBNUM = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s0_req = 1'b0, s1_req = 1'b0;
  logic [31:0]   s0_vaddr = '0, s1_vaddr = '0;
  logic [7:0]    cur_asid = '0;
  logic          s0_rsp_valid, s0_found, s0_d, s0_v;
  logic          s1_rsp_valid, s1_found, s1_d, s1_v;
  logic [31:0]   s0_paddr, s1_paddr;
  logic [2:0]    s0_c, s1_c;
  logic          tlbp_req = 1'b0;
  logic [31:0]   tlbp_entryhi = '0;
  logic          tlbp_wen;
  logic [31:0]   tlbp_index;
  logic          tlbr_req = 1'b0;
  logic [IW-1:0] tlb_index = '0;
  logic          tlbr_wen;
  logic [77:0]   tlbr_entry;
  logic          tlbwi_wen = 1'b0;
  logic [77:0]   tlbwi_entry = '0;

  int n_tests = 0;
  int n_fail  = 0;

  tlb #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .rst(rst),
    .s0_req(s0_req), .s0_vaddr(s0_vaddr), .s1_req(s1_req), .s1_vaddr(s1_vaddr),
    .cur_asid(cur_asid),
    .s0_rsp_valid(s0_rsp_valid), .s0_found(s0_found), .s0_paddr(s0_paddr),
    .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
    .s1_rsp_valid(s1_rsp_valid), .s1_found(s1_found), .s1_paddr(s1_paddr),
    .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
    .tlbp_req(tlbp_req), .tlbp_entryhi(tlbp_entryhi),
    .tlbp_wen(tlbp_wen), .tlbp_index(tlbp_index),
    .tlbr_req(tlbr_req), .tlb_index(tlb_index),
    .tlbr_wen(tlbr_wen), .tlbr_entry(tlbr_entry),
    .tlbwi_wen(tlbwi_wen), .tlbwi_entry(tlbwi_entry)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [77:0] act, input logic [77:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [77:0] mk_entry(
      input logic [18:0] vpn2, input logic [7:0] asid, input logic g,
      input logic [19:0] pfn0, input logic [2:0] c0, input logic d0, input logic v0,
      input logic [19:0] pfn1, input logic [2:0] c1, input logic d1, input logic v1);
    return {vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1};
  endfunction

  function automatic logic [77:0] filler(input int i);
    return mk_entry(19'h70000 + 19'(i), 8'hFF, 1'b0,
                    20'hF0000 + 20'(i), 3'd0, 1'b0, 1'b1,
                    20'hE0000 + 20'(i), 3'd0, 1'b0, 1'b1);
  endfunction

  // Reference model: plain array, first match in index order wins.
  logic [77:0] m_tlb [TLBNUM];

  function automatic logic [37:0] model_lookup(input logic [31:0] va, input logic [7:0] asid);
    logic [77:0] e;
    logic [24:0] pg;
    for (int i = 0; i < TLBNUM; i++) begin
      e = m_tlb[i];
      if (e[77:59] == va[31:13] && (e[50] || e[58:51] == asid)) begin
        pg = va[12] ? e[24:0] : e[49:25];
        return {1'b1, pg[24:5], va[11:0], pg[4:2], pg[1], pg[0]};
      end
    end
    return '0;
  endfunction

  function automatic logic [31:0] model_probe(input logic [31:0] hi);
    logic [77:0] e;
    for (int i = 0; i < TLBNUM; i++) begin
      e = m_tlb[i];
      if (e[77:59] == hi[31:13] && (e[50] || e[58:51] == hi[7:0])) return 32'(i);
    end
    return 32'h8000_0000;
  endfunction

  logic        e_s0_valid = 1'b0, e_s1_valid = 1'b0, e_p_wen = 1'b0, e_r_wen = 1'b0;
  logic [37:0] e_s0 = '0, e_s1 = '0;
  logic [31:0] e_p_index = '0;
  logic [77:0] e_r_entry = '0;

  initial for (int i = 0; i < TLBNUM; i++) m_tlb[i] = '0;

  // Model update on each edge from sampled inputs, then compare shortly after.
  always @(posedge clk) begin
    if (rst) begin
      e_s0_valid = 1'b0; e_s1_valid = 1'b0; e_p_wen = 1'b0; e_r_wen = 1'b0;
      e_s0 = '0; e_s1 = '0; e_p_index = '0; e_r_entry = '0;
`ifdef TLB_RESET_CLEAR_EN
      for (int i = 0; i < TLBNUM; i++) m_tlb[i] = '0;
`else
      if (tlbwi_wen) m_tlb[tlb_index] = tlbwi_entry;
`endif
    end else begin
      e_s0_valid = s0_req;
      e_s1_valid = s1_req;
      e_p_wen    = tlbp_req;
      e_r_wen    = tlbr_req;
      if (s0_req)   e_s0 = model_lookup(s0_vaddr, cur_asid);
      if (s1_req)   e_s1 = model_lookup(s1_vaddr, cur_asid);
      if (tlbp_req) e_p_index = model_probe(tlbp_entryhi);
      if (tlbr_req) e_r_entry = m_tlb[tlb_index];
      if (tlbwi_wen) m_tlb[tlb_index] = tlbwi_entry;
    end
    #1;
    check("s0_rsp_valid", 78'(s0_rsp_valid), 78'(e_s0_valid));
    check("s0_result", 78'({s0_found, s0_paddr, s0_c, s0_d, s0_v}), 78'(e_s0));
    check("s1_rsp_valid", 78'(s1_rsp_valid), 78'(e_s1_valid));
    check("s1_result", 78'({s1_found, s1_paddr, s1_c, s1_d, s1_v}), 78'(e_s1));
    check("tlbp_wen", 78'(tlbp_wen), 78'(e_p_wen));
    check("tlbp_index", 78'(tlbp_index), 78'(e_p_index));
    check("tlbr_wen", 78'(tlbr_wen), 78'(e_r_wen));
    check("tlbr_entry", tlbr_entry, e_r_entry);
  end

  task automatic clear_reqs();
    s0_req = 1'b0; s1_req = 1'b0; tlbp_req = 1'b0; tlbr_req = 1'b0; tlbwi_wen = 1'b0;
  endtask

  task automatic write_entry(input logic [IW-1:0] idx, input logic [77:0] e);
    @(negedge clk);
    clear_reqs();
    tlbwi_wen = 1'b1; tlb_index = idx; tlbwi_entry = e;
    @(posedge clk);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  logic [77:0] e3, e3g, e9, e5, e7n, e2;

  initial begin
    e3  = mk_entry(19'h00040, 8'h05, 1'b0, 20'h12345, 3'd3, 1'b1, 1'b1, 20'hABCDE, 3'd2, 1'b0, 1'b1);
    e3g = mk_entry(19'h00040, 8'h05, 1'b1, 20'h12345, 3'd3, 1'b1, 1'b1, 20'hABCDE, 3'd2, 1'b0, 1'b1);
    e9  = mk_entry(19'h00040, 8'h05, 1'b0, 20'h99999, 3'd1, 1'b0, 1'b1, 20'h99998, 3'd1, 1'b0, 1'b1);
    e5  = mk_entry(19'h00100, 8'h05, 1'b0, 20'h55555, 3'd2, 1'b1, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0);
    e7n = mk_entry(19'h00200, 8'h05, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0, 20'h77777, 3'd5, 1'b1, 1'b1);
    e2  = mk_entry(19'h00300, 8'h01, 1'b0, 20'h22222, 3'd1, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    check("reset_s0_valid", 78'(s0_rsp_valid), 78'h0);
    check("reset_s0_paddr", 78'(s0_paddr), 78'h0);
    check("reset_tlbp_index", 78'(tlbp_index), 78'h0);
    check("reset_tlbr_entry", tlbr_entry, 78'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < TLBNUM; i++) write_entry(IW'(i), filler(i));
    write_entry(4'd3, e3);

    // Even page on s0, odd page on s1, same entry.
    @(negedge clk); clear_reqs();
    s0_req = 1'b1; s0_vaddr = 32'h0008_0ABC; cur_asid = 8'h05;
    s1_req = 1'b1; s1_vaddr = 32'h0008_1123;
    settle();
    check("lit_s0_valid", 78'(s0_rsp_valid), 78'h1);
    check("lit_s0_found", 78'(s0_found), 78'h1);
    check("lit_s0_paddr", 78'(s0_paddr), 78'h1234_5ABC);
    check("lit_s0_cdv", 78'({s0_c, s0_d, s0_v}), 78'b011_1_1);
    check("lit_s1_paddr", 78'(s1_paddr), 78'hABCD_E123);
    check("lit_s1_cdv", 78'({s1_c, s1_d, s1_v}), 78'b010_0_1);

    @(negedge clk); clear_reqs();
    settle();
    check("lit_hold_valid", 78'(s0_rsp_valid), 78'h0);
    check("lit_hold_paddr", 78'(s0_paddr), 78'h1234_5ABC);

    @(negedge clk); clear_reqs();
    s0_req = 1'b1; s0_vaddr = 32'h0008_0ABC; cur_asid = 8'h06;
    settle();
    check("lit_asid_miss_found", 78'(s0_found), 78'h0);
    check("lit_asid_miss_paddr", 78'(s0_paddr), 78'h0);

    write_entry(4'd3, e3g);
    @(negedge clk); clear_reqs();
    s0_req = 1'b1; s0_vaddr = 32'h0008_0ABC; cur_asid = 8'h06;
    settle();
    check("lit_global_found", 78'(s0_found), 78'h1);
    check("lit_global_paddr", 78'(s0_paddr), 78'h1234_5ABC);

    write_entry(4'd9, e9);
    @(negedge clk); clear_reqs();
    tlbp_req = 1'b1; tlbp_entryhi = 32'h0008_0005;
    s1_req = 1'b1; s1_vaddr = 32'h0008_0ABC; cur_asid = 8'h05;
    settle();
    check("lit_probe_wen", 78'(tlbp_wen), 78'h1);
    check("lit_probe_hit", 78'(tlbp_index), 78'h3);
    check("lit_s1_lowest", 78'(s1_paddr), 78'h1234_5ABC);

    @(negedge clk); clear_reqs();
    tlbp_req = 1'b1; tlbp_entryhi = 32'h1234_0005;
    settle();
    check("lit_probe_miss", 78'(tlbp_index), 78'h8000_0000);

    write_entry(4'd5, e5);
    @(negedge clk); clear_reqs();
    s0_req = 1'b1; s0_vaddr = 32'h0020_0345; cur_asid = 8'h05;
    settle();
    check("lit_v0_found", 78'(s0_found), 78'h1);
    check("lit_v0_paddr", 78'(s0_paddr), 78'h5555_5345);
    check("lit_v0_cdv", 78'({s0_c, s0_d, s0_v}), 78'b010_1_0);

    // Write, read and lookup of idx 7 on the same edge see the old contents.
    @(negedge clk); clear_reqs();
    tlbwi_wen = 1'b1; tlb_index = 4'd7; tlbwi_entry = e7n;
    tlbr_req = 1'b1;
    s0_req = 1'b1; s0_vaddr = 32'h0040_1FFF;
    settle();
    check("lit_rbw_tlbr_old", tlbr_entry, filler(7));
    check("lit_rbw_s0_miss", 78'(s0_found), 78'h0);
    @(negedge clk); clear_reqs();
    tlbr_req = 1'b1; tlb_index = 4'd7;
    s0_req = 1'b1; s0_vaddr = 32'h0040_1FFF;
    settle();
    check("lit_rbw_tlbr_new", tlbr_entry, e7n);
    check("lit_rbw_s0_paddr", 78'(s0_paddr), 78'h7777_7FFF);
    check("lit_rbw_s0_c", 78'(s0_c), 78'h5);

    // Reset drops concurrent requests; the write is kept only without array clear.
    @(negedge clk); clear_reqs();
    rst = 1'b1;
    s0_req = 1'b1; s1_req = 1'b1; tlbp_req = 1'b1; tlbr_req = 1'b1;
    tlbwi_wen = 1'b1; tlb_index = 4'd2; tlbwi_entry = e2;
    settle();
    check("lit_rst_s0_valid", 78'(s0_rsp_valid), 78'h0);
    check("lit_rst_s1_valid", 78'(s1_rsp_valid), 78'h0);
    check("lit_rst_tlbp_wen", 78'(tlbp_wen), 78'h0);
    check("lit_rst_tlbr_wen", 78'(tlbr_wen), 78'h0);
    check("lit_rst_s0_paddr", 78'(s0_paddr), 78'h0);
    @(negedge clk); clear_reqs();
    rst = 1'b0;
    tlbr_req = 1'b1; tlb_index = 4'd2;
    settle();
`ifdef TLB_RESET_CLEAR_EN
    check("lit_post_rst_idx2", tlbr_entry, 78'h0);
`else
    check("lit_post_rst_idx2", tlbr_entry, e2);
`endif
    @(negedge clk); clear_reqs();
    tlbr_req = 1'b1; tlb_index = 4'd3;
    settle();
`ifdef TLB_RESET_CLEAR_EN
    check("lit_post_rst_idx3", tlbr_entry, 78'h0);
`else
    check("lit_post_rst_idx3", tlbr_entry, e3g);
`endif

    @(negedge clk); clear_reqs();
    repeat (3) @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
